addr_decoding: RTL and testbench

- Address decoder that classifies a 32-bit CPU address as internal (on-chip data memory) or external memory.
- Produces a chip-select and the local offset into the internal memory window.
- Sits between the CPU datapath address bus and the internal/external memory muxing.
- Provides a combinational decode and a one-cycle registered copy for pipelined consumers.

---
 rtl/addr_decoding.sv | 140 ++++++++++++++
 tb/tb_addr_decoding.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/addr_decoding.sv
// ---------------------------------------------------------------------------
// addr_decoding
//   Classifies a 32-bit CPU byte address as internal data memory or external
//   memory. The internal window is [BASE_ADDR, LIMIT_ADDR], inclusive, and is
//   decoded with a full 32-bit unsigned compare, so there is no aliasing.
//   A zero-latency combinational decode is provided, together with a copy
//   registered on clk for pipelined consumers.
//
// Parameters
//   BASE_ADDR   first byte address of the internal window (inclusive)
//   LIMIT_ADDR  last byte address of the internal window (inclusive)
//   OFFSET_W    width of the local offset; the window must fit in 2**OFFSET_W
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset (registered path only)
//   addr          CPU byte address
//   addr_valid    addr carries a real access this cycle
//   cs            combinational select: 0 = internal, 1 = external
//   int_offset    combinational addr - BASE_ADDR; 0 when cs = 1
//   cs_q          cs registered (resets to 1, the external/safe side)
//   int_offset_q  int_offset registered (resets to 0)
//   valid_q       addr_valid registered (resets to 0)
//
// Optional feature (macro ADDR_DECODING_HIT_CNT_EN)
//   int_hits      count of valid accesses that decoded internal (wraps)
//   ext_hits      count of valid accesses that decoded external (wraps)
// ---------------------------------------------------------------------------
module addr_decoding #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0A00,
  parameter logic [31:0] LIMIT_ADDR = 32'h0000_0DFF,
  parameter int          OFFSET_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr,
  input  logic                addr_valid,
  output logic                cs,
  output logic [OFFSET_W-1:0] int_offset,
  output logic                cs_q,
  output logic [OFFSET_W-1:0] int_offset_q,
  output logic                valid_q
`ifdef ADDR_DECODING_HIT_CNT_EN
  ,
  output logic [31:0]         int_hits,
  output logic [31:0]         ext_hits
`endif
);

  // Window size in bytes, computed one bit wider so a full 4 GiB window
  // cannot overflow the check.
  localparam logic [32:0] WIN_BYTES = {1'b0, LIMIT_ADDR} - {1'b0, BASE_ADDR} + 33'd1;

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (OFFSET_W < 1 || OFFSET_W > 32) begin : g_bad_offset_w
      $error("addr_decoding: OFFSET_W must be in 1..32");
    end else if (BASE_ADDR > LIMIT_ADDR) begin : g_bad_range
      $error("addr_decoding: BASE_ADDR is above LIMIT_ADDR");
    end else if (WIN_BYTES > (33'd1 << OFFSET_W)) begin : g_bad_window
      $error("addr_decoding: window does not fit in 2**OFFSET_W bytes");
    end
  endgenerate

  logic                in_window;
  logic                cs_d;
  logic [OFFSET_W-1:0] int_offset_d;
  logic                valid_d;

  // Combinational decode. Only the low OFFSET_W bits of the difference are
  // needed, and modular subtraction of the low bits gives exactly those.
  always_comb begin
    in_window = (addr >= BASE_ADDR) && (addr <= LIMIT_ADDR);
    if (in_window) begin
      cs         = 1'b0;
      int_offset = addr[OFFSET_W-1:0] - BASE_ADDR[OFFSET_W-1:0];
    end else begin
      cs         = 1'b1;
      int_offset = '0;
    end
  end

  // Next-state values for the registered copy.
  always_comb begin
    cs_d         = cs;
    int_offset_d = int_offset;
    valid_d      = addr_valid;
  end

  // Registered copy; captures every edge regardless of addr_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q         <= 1'b1;
      int_offset_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      cs_q         <= cs_d;
      int_offset_q <= int_offset_d;
      valid_q      <= valid_d;
    end
  end

`ifdef ADDR_DECODING_HIT_CNT_EN
  logic [31:0] int_hits_d;
  logic [31:0] int_hits_q;
  logic [31:0] ext_hits_d;
  logic [31:0] ext_hits_q;

  // Hit counters advance only on qualified accesses and wrap naturally.
  always_comb begin
    int_hits_d = int_hits_q;
    ext_hits_d = ext_hits_q;
    if (addr_valid) begin
      if (cs) begin
        ext_hits_d = ext_hits_q + 32'd1;
      end else begin
        int_hits_d = int_hits_q + 32'd1;
      end
    end else begin
      int_hits_d = int_hits_q;
      ext_hits_d = ext_hits_q;
    end
  end

  // Hit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_hits_q <= 32'd0;
      ext_hits_q <= 32'd0;
    end else begin
      int_hits_q <= int_hits_d;
      ext_hits_q <= ext_hits_d;
    end
  end

  assign int_hits = int_hits_q;
  assign ext_hits = ext_hits_q;
`endif

endmodule

// File: tb/tb_addr_decoding.sv
// ---------------------------------------------------------------------------
// tb_addr_decoding
//   Self-checking bench for addr_decoding. Two instances are exercised: one
//   with default parameters and one with a small 0x100..0x1FF / 8-bit window.
//   Expected values come from a window-membership reference model plus
//   fixed boundary constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_addr_decoding;

  localparam logic [31:0] BA0 = 32'h0000_0A00;
  localparam logic [31:0] LA0 = 32'h0000_0DFF;
  localparam int          OW0 = 10;
  localparam logic [31:0] BA1 = 32'h0000_0100;
  localparam logic [31:0] LA1 = 32'h0000_01FF;
  localparam int          OW1 = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        addr_valid = 1'b0;

  logic           cs0, cs_q0, valid_q0;
  logic [OW0-1:0] off0, off_q0;
  logic           cs1, cs_q1, valid_q1;
  logic [OW1-1:0] off1, off_q1;
`ifdef ADDR_DECODING_HIT_CNT_EN
  logic [31:0] ih0, eh0, ih1, eh1;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  // Model state for the registered path and counters.
  logic [31:0] m_ih0 = 32'd0, m_eh0 = 32'd0, m_ih1 = 32'd0, m_eh1 = 32'd0;

  always #5 clk = ~clk;

  addr_decoding u_dut (
    .clk(clk), .rst(rst), .addr(addr), .addr_valid(addr_valid),
    .cs(cs0), .int_offset(off0), .cs_q(cs_q0), .int_offset_q(off_q0),
    .valid_q(valid_q0)
`ifdef ADDR_DECODING_HIT_CNT_EN
    , .int_hits(ih0), .ext_hits(eh0)
`endif
  );

  addr_decoding #(.BASE_ADDR(BA1), .LIMIT_ADDR(LA1), .OFFSET_W(OW1)) u_dut_small (
    .clk(clk), .rst(rst), .addr(addr), .addr_valid(addr_valid),
    .cs(cs1), .int_offset(off1), .cs_q(cs_q1), .int_offset_q(off_q1),
    .valid_q(valid_q1)
`ifdef ADDR_DECODING_HIT_CNT_EN
    , .int_hits(ih1), .ext_hits(eh1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (addr=0x%08h t=%0t)", tag, obs, exp, addr, $time);
    end
  endtask

  // Reference: is the address outside the inclusive window?
  function automatic logic m_ext(input logic [31:0] a, input logic [31:0] b, input logic [31:0] l);
    return (a < b) || (a > l);
  endfunction

  function automatic logic [31:0] m_off(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] l, input int w);
    logic [63:0] d;
    if (m_ext(a, b, l)) return 32'd0;
    d = {32'd0, a} - {32'd0, b};
    return 32'(d % (64'd1 << w));
  endfunction

  // One clock of stimulus: drive at negedge, check combinational outputs,
  // then check the registered path just after the next rising edge.
  task automatic step(input logic [31:0] a, input logic v, input logic r);
    logic e0, e1;
    logic [31:0] o0, o1;
    addr = a; addr_valid = v; rst = r;
    e0 = m_ext(a, BA0, LA0); o0 = m_off(a, BA0, LA0, OW0);
    e1 = m_ext(a, BA1, LA1); o1 = m_off(a, BA1, LA1, OW1);
    #1;
    check("cs", {31'd0, cs0}, {31'd0, e0});
    check("int_offset", {22'd0, off0}, o0);
    check("cs_small", {31'd0, cs1}, {31'd0, e1});
    check("int_offset_small", {24'd0, off1}, o1);
    @(posedge clk); #1;
    if (r) begin
      m_ih0 = 32'd0; m_eh0 = 32'd0; m_ih1 = 32'd0; m_eh1 = 32'd0;
      check("cs_q_rst", {31'd0, cs_q0}, 32'd1);
      check("int_offset_q_rst", {22'd0, off_q0}, 32'd0);
      check("valid_q_rst", {31'd0, valid_q0}, 32'd0);
      check("cs_q_small_rst", {31'd0, cs_q1}, 32'd1);
      check("valid_q_small_rst", {31'd0, valid_q1}, 32'd0);
    end else begin
      if (v) begin
        if (e0) m_eh0 = m_eh0 + 32'd1; else m_ih0 = m_ih0 + 32'd1;
        if (e1) m_eh1 = m_eh1 + 32'd1; else m_ih1 = m_ih1 + 32'd1;
      end
      check("cs_q", {31'd0, cs_q0}, {31'd0, e0});
      check("int_offset_q", {22'd0, off_q0}, o0);
      check("valid_q", {31'd0, valid_q0}, {31'd0, v});
      check("cs_q_small", {31'd0, cs_q1}, {31'd0, e1});
      check("int_offset_q_small", {24'd0, off_q1}, o1);
      check("valid_q_small", {31'd0, valid_q1}, {31'd0, v});
    end
`ifdef ADDR_DECODING_HIT_CNT_EN
    check("int_hits", ih0, m_ih0);
    check("ext_hits", eh0, m_eh0);
    check("int_hits_small", ih1, m_ih1);
    check("ext_hits_small", eh1, m_eh1);
`endif
    @(negedge clk);
  endtask

  logic [31:0] sweep_a [10] = '{32'h09FF, 32'h0A00, 32'h0AFF, 32'h0B00, 32'h0BFF,
                                32'h0C00, 32'h0CFF, 32'h0D00, 32'h0DFF, 32'h0E00};
  logic        sweep_cs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] sweep_o [10] = '{32'h000, 32'h000, 32'h0FF, 32'h100, 32'h1FF,
                                32'h200, 32'h2FF, 32'h300, 32'h3FF, 32'h000};
  logic [31:0] small_a [4]  = '{32'h0FF, 32'h100, 32'h1FF, 32'h200};
  logic        small_cs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] small_o [4]  = '{32'h00, 32'h00, 32'hFF, 32'h00};
  logic [31:0] edges   [8]  = '{32'h09FF, 32'h0A00, 32'h0DFF, 32'h0E00,
                                32'h00FF, 32'h0100, 32'h01FF, 32'h0200};

  initial begin
    @(negedge clk);

    // Reset held two cycles with an in-window address.
    step(32'h0A10, 1'b1, 1'b1);
    step(32'h0A10, 1'b1, 1'b1);
    check("cs_during_rst", {31'd0, cs0}, 32'd0);
    step(32'h0A10, 1'b1, 1'b0);
    check("cs_q_after_rst", {31'd0, cs_q0}, 32'd0);
    check("int_offset_q_after_rst", {22'd0, off_q0}, 32'h010);

    // Boundary sweep, each address held 20 ns, against fixed constants too.
    for (int i = 0; i < 10; i++) begin
      step(sweep_a[i], 1'b1, 1'b0);
      check("sweep_cs", {31'd0, cs0}, {31'd0, sweep_cs[i]});
      check("sweep_offset", {22'd0, off0}, sweep_o[i]);
      step(sweep_a[i], 1'b1, 1'b0);
    end

    // Full 32-bit decode: no aliasing, no wrap-around.
    step(32'h1000_0A00, 1'b1, 1'b0);
    check("alias_cs", {31'd0, cs0}, 32'd1);
    check("alias_offset", {22'd0, off0}, 32'd0);
    step(32'hFFFF_FFFF, 1'b1, 1'b0);
    check("top_cs", {31'd0, cs0}, 32'd1);
    check("top_offset", {22'd0, off0}, 32'd0);

    // Back-to-back 0x0DFF then 0x0E00: cs_q lags cs by exactly one cycle.
    step(32'h0DFF, 1'b1, 1'b0);
    check("lag_cs_q_0", {31'd0, cs_q0}, 32'd0);
    check("lag_cs_now_1", {31'd0, cs0}, 32'd0);
    step(32'h0E00, 1'b1, 1'b0);
    check("lag_cs_q_1", {31'd0, cs_q0}, 32'd1);
    check("lag_valid_q", {31'd0, valid_q0}, 32'd1);

    // Small-window instance boundaries.
    for (int i = 0; i < 4; i++) begin
      step(small_a[i], 1'b0, 1'b0);
      check("small_cs", {31'd0, cs1}, {31'd0, small_cs[i]});
      check("small_offset", {24'd0, off1}, small_o[i]);
    end

    // Hit counter scenario from a clean reset.
    step(32'h0B00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(32'h0B00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(32'h2000, 1'b1, 1'b0);
    step(32'h0B00, 1'b0, 1'b0);
`ifdef ADDR_DECODING_HIT_CNT_EN
    check("hits_int_3", ih0, 32'd3);
    check("hits_ext_2", eh0, 32'd2);
    step(32'h0B00, 1'b1, 1'b1);
    check("hits_int_clr", ih0, 32'd0);
    check("hits_ext_clr", eh0, 32'd0);
`endif

    // Randomized addresses, valids and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom();
        1:       a = 32'($urandom_range(32'h0900, 32'h0F00));
        2:       a = 32'($urandom_range(32'h00F0, 32'h0210));
        default: a = edges[$urandom_range(0, 7)];
      endcase
      step(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
